mem_access_unit: RTL and testbench

Load/store unit for the MEM stage of the pipelined MIPS core. It sits directly upstream of the data memory: it drives the memory's address, write data, write enable and byte-write select, and it consumes the memory's combinational read data. It turns sb/sh/sw/lb/lbu/lh/lhu/lw requests into correct little-endian lane accesses. The memory's byte-write path only writes bits [7:0] of the addressed word, so every sub-word store that needs another lane becomes a two-cycle read-modify-write that stalls the pipeline for one cycle.

---
 rtl/mem_access_unit.sv | 74 +++++++
 tb/tb_mem_access_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit with read-modify-write sub-word stores
module mem_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        misalign,
    output logic        fault,
    output logic [31:0] fault_addr,
    output logic        mem_we,
    output logic        mem_worb,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);
    typedef enum logic {IDLE, MERGE} state_t;
    state_t state, state_next;
    logic [31:0] merge_q, pend_q;
    logic is_word, is_half, is_byte, bad_align, go, rmw;
    logic [4:0] shamt;
    logic [31:0] lane_mask, merged, rd_shift;
    assign is_word   = req_size[1];
    assign is_half   = req_size == 2'b01;
    assign is_byte   = req_size == 2'b00;
    assign bad_align = (is_half & req_addr[0]) | (is_word & |req_addr[1:0]);
    assign misalign  = (state == IDLE) & req_valid & bad_align;
    assign go        = (state == IDLE) & req_valid & ~bad_align;
    assign rmw       = go & req_write & (is_half | (is_byte & |req_addr[1:0]));
    assign shamt     = {req_addr[1:0], 3'b000};
    assign lane_mask = (is_half ? 32'h0000_FFFF : 32'h0000_00FF) << shamt;
    assign merged    = (mem_rd & ~lane_mask) | ((req_wdata << shamt) & lane_mask);
    assign rd_shift  = mem_rd >> shamt;
    // state register
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_next;
    // next state: a sub-word store needing a merge spends one cycle in MERGE
    always_comb state_next = rmw ? MERGE : IDLE;
    // outputs: MERGE replays the latched word, IDLE serves the live request
    always_comb begin
        stall     = rmw;
        mem_we    = (state == MERGE) | (go & req_write & ~rmw);
        mem_worb  = go & req_write & is_byte & ~|req_addr[1:0];
        mem_a     = (state == MERGE) ? pend_q : req_addr;
        mem_wd    = (state == MERGE) ? merge_q : req_wdata;
        load_data = !(go & ~req_write) ? 32'h0 :
                    is_word ? rd_shift :
                    is_half ? {{16{~req_unsigned & rd_shift[15]}}, rd_shift[15:0]} :
                              {{24{~req_unsigned & rd_shift[7]}}, rd_shift[7:0]};
    end
    // merge/pending capture and sticky first-fault record
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            merge_q    <= '0;
            pend_q     <= '0;
            fault      <= 1'b0;
            fault_addr <= '0;
        end else begin
            if (rmw) begin
                pend_q  <= {req_addr[31:2], 2'b00};
                merge_q <= merged;
            end
            if (misalign & ~fault) begin
                fault      <= 1'b1;
                fault_addr <= req_addr;
            end
        end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and random checks of mem_access_unit against a byte-level model
module tb_mem_access_unit;
    logic clk = 0, reset = 1;
    logic req_valid = 0, req_write = 0, req_unsigned = 0;
    logic [1:0] req_size = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic stall, misalign, fault, mem_we, mem_worb;
    logic [31:0] load_data, fault_addr, mem_a, mem_wd, mem_rd;
    logic [31:0] dmem [0:63];
    logic pre_en = 0, clr = 0;
    logic [5:0] pre_idx = 0;
    logic [31:0] pre_val = 0;
    logic [7:0] rb [0:255];
    logic exp_fault = 0;
    logic [31:0] exp_faddr = 0;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .stall(stall), .load_data(load_data),
        .misalign(misalign), .fault(fault), .fault_addr(fault_addr),
        .mem_we(mem_we), .mem_worb(mem_worb), .mem_a(mem_a), .mem_wd(mem_wd),
        .mem_rd(mem_rd)
    );

    assign mem_rd = dmem[mem_a[7:2]];

    // data memory: byte-write path only updates bits [7:0]
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 64; i++) dmem[i] <= '0;
        end else if (pre_en) dmem[pre_idx] <= pre_val;
        else if (mem_we) begin
            if (mem_worb) dmem[mem_a[7:2]][7:0] <= mem_wd[7:0];
            else dmem[mem_a[7:2]] <= mem_wd;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [7:0] a);
        logic [7:0] b;
        b = {a[7:2], 2'b00};
        return {rb[b + 8'd3], rb[b + 8'd2], rb[b + 8'd1], rb[b]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic u, input logic [7:0] a);
        logic [15:0] h;
        if (sz == 2'd0) return u ? {24'h0, rb[a]} : {{24{rb[a][7]}}, rb[a]};
        if (sz == 2'd1) begin
            h = {rb[a + 8'd1], rb[a]};
            return u ? {16'h0, h} : {{16{h[15]}}, h};
        end
        return ref_word(a);
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [7:0] a, input logic [31:0] d);
        int n;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        for (int i = 0; i < n; i++) rb[a + 8'(i)] = d[8*i +: 8];
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] v);
        @(negedge clk);
        pre_en = 1; pre_idx = a[7:2]; pre_val = v;
        for (int i = 0; i < 4; i++) rb[{a[7:2], 2'b00} + 8'(i)] = v[8*i +: 8];
        @(negedge clk);
        pre_en = 0;
    endtask

    task automatic op(input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] d);
        logic mis, rmw;
        mis = (sz == 2'd1 && a[0]) || (sz[1] && a[1:0] != 2'b00);
        rmw = w && !mis && (sz == 2'd1 || (sz == 2'd0 && a[1:0] != 2'b00));
        @(negedge clk);
        req_valid = 1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = d;
        #1;
        chk("misalign", {31'h0, misalign}, {31'h0, mis});
        chk("stall", {31'h0, stall}, {31'h0, rmw});
        if (!w) chk("load_data", load_data, mis ? 32'h0 : ref_load(sz, u, a[7:0]));
        else begin
            chk("mem_we", {31'h0, mem_we}, {31'h0, !mis && !rmw});
            if (!mis && !rmw) chk("mem_worb", {31'h0, mem_worb}, {31'h0, sz == 2'd0});
        end
        if (mis && !exp_fault) begin exp_fault = 1; exp_faddr = a; end
        if (w && !mis) ref_store(sz, a[7:0], d);
        @(posedge clk);
        if (rmw) begin
            @(negedge clk);
            req_valid = 0;
            #1;
            chk("merge_stall", {31'h0, stall}, 32'h0);
            chk("merge_we", {31'h0, mem_we}, 32'h1);
            chk("merge_addr", mem_a, {a[31:2], 2'b00});
            @(posedge clk);
        end
        @(negedge clk);
        req_valid = 0;
        #1;
        chk("fault", {31'h0, fault}, {31'h0, exp_fault});
        chk("fault_addr", fault_addr, exp_faddr);
        chk("word", dmem[a[7:2]], ref_word(a[7:0]));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rb[i] = 8'h0;
        clr = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 0;
        #1;
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_we", {31'h0, mem_we}, 32'h0);
        chk("rst_fault", {31'h0, fault}, 32'h0);
        chk("rst_faddr", fault_addr, 32'h0);
        chk("rst_ld", load_data, 32'h0);
        reset = 0;
        preload(8'h10, 32'h1122_3344);
        op(0, 2'd0, 0, 32'h13, 0);
        op(0, 2'd0, 1, 32'h10, 0);
        op(0, 2'd1, 0, 32'h12, 0);
        preload(8'h10, 32'hF0F0_8000);
        op(0, 2'd1, 0, 32'h10, 0);
        op(0, 2'd1, 1, 32'h10, 0);
        preload(8'h10, 32'h1122_3344);
        op(1, 2'd0, 0, 32'h11, 32'hAB);
        chk("sb11", dmem[4], 32'h1122_AB44);
        op(1, 2'd0, 0, 32'h10, 32'hCD);
        chk("sb10", dmem[4], 32'h1122_ABCD);
        op(1, 2'd1, 0, 32'h12, 32'hBEEF);
        op(1, 2'd0, 0, 32'h10, 32'h55);
        chk("sh_sb", dmem[4], 32'hBEEF_AB55);
        op(1, 2'd2, 0, 32'h21, 32'h1234_5678);
        op(0, 2'd1, 0, 32'h31, 0);
        chk("fault_keep", fault_addr, 32'h21);
        @(negedge clk);
        req_valid = 1; req_write = 1; req_size = 2'd1; req_addr = 32'h12; req_wdata = 32'hAAAA;
        #1;
        chk("rst_mrg_stall0", {31'h0, stall}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 0; reset = 1;
        #1;
        chk("rst_mrg_stall", {31'h0, stall}, 32'h0);
        chk("rst_mrg_we", {31'h0, mem_we}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 0; exp_fault = 0; exp_faddr = 0;
        #1;
        chk("rst_mrg_word", dmem[4], 32'hBEEF_AB55);
        chk("rst_mrg_fault", {31'h0, fault}, 32'h0);
        op(0, 2'd2, 0, 32'h10, 0);
        op(1, 2'd2, 0, 32'h40, 32'hDEAD_BEEF);
        op(0, 2'd2, 0, 32'h40, 0);
        chk("lw40", dmem[16], 32'hDEAD_BEEF);
        for (int i = 0; i < 300; i++)
            op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               32'($urandom_range(0, 255)), $urandom);
        for (int i = 0; i < 64; i++) chk("final", dmem[i], ref_word(8'(i * 4)));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
